// File: rtl/mux_16x1_pkg.sv
// Shared constants and select type for the registered 16:1 lane selector.
package mux_16x1_pkg;

  localparam int NUM_LANES  = 16;
  localparam int SEL_W      = 4;
  localparam int GROUP_SIZE = 4;
  localparam int NUM_GROUPS = NUM_LANES / GROUP_SIZE;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_16x1_if.sv
// Lane/select input bus and registered result bus of the 16:1 selector.
interface mux_16x1_if
  import mux_16x1_pkg::*;
#(
  parameter int W = 1
);

  logic                   in_valid;
  logic [NUM_LANES*W-1:0] d;
  sel_t                   s;
  logic [W-1:0]           y;
  logic                   out_valid;

  modport master (output in_valid, output d, output s, input y, input out_valid);
  modport slave  (input in_valid, input d, input s, output y, output out_valid);

endinterface

// File: rtl/mux_4x1.sv
// Combinational 4:1 selector of W-bit lanes; building block of the 16:1 tree.
module mux_4x1 #(
  parameter int W = 1
) (
  input  logic [W-1:0] lane0,
  input  logic [W-1:0] lane1,
  input  logic [W-1:0] lane2,
  input  logic [W-1:0] lane3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = lane0;
    unique case (sel)
      2'd0: y = lane0;
      2'd1: y = lane1;
      2'd2: y = lane2;
      2'd3: y = lane3;
      default: y = lane0;
    endcase
  end

endmodule

// File: rtl/mux_16x1.sv
// Registered 16:1 lane selector built as a two-level tree of 4:1 muxes.
// Optional MUX_16X1_PIPE2_EN adds a register after level 1 (2-clock latency).
module mux_16x1
  import mux_16x1_pkg::*;
#(
  parameter int W = 1
) (
  input  logic       clk,
  input  logic       rst,
  mux_16x1_if.slave  bus
);

  logic [W-1:0] grp_p0 [NUM_GROUPS];
  logic [W-1:0] lvl2_p1;

  // Stage 0: level-1 muxes, each picking within its group of four lanes on s[1:0]
  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_lvl1
    mux_4x1 #(.W(W)) u_lvl1 (
      .lane0 (bus.d[(g*GROUP_SIZE+0)*W +: W]),
      .lane1 (bus.d[(g*GROUP_SIZE+1)*W +: W]),
      .lane2 (bus.d[(g*GROUP_SIZE+2)*W +: W]),
      .lane3 (bus.d[(g*GROUP_SIZE+3)*W +: W]),
      .sel   (bus.s[1:0]),
      .y     (grp_p0[g])
    );
  end

`ifdef MUX_16X1_PIPE2_EN

  logic [W-1:0] grp_p1 [NUM_GROUPS];
  logic [1:0]   sel_hi_p1;
  logic         vld_p1;
  logic [W-1:0] y_p2;
  logic         vld_p2;

  // Stage 1: group results and upper select bits registered
  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      grp_p1    <= grp_p0;
      sel_hi_p1 <= bus.s[3:2];
    end
  end

  mux_4x1 #(.W(W)) u_lvl2 (
    .lane0 (grp_p1[0]),
    .lane1 (grp_p1[1]),
    .lane2 (grp_p1[2]),
    .lane3 (grp_p1[3]),
    .sel   (sel_hi_p1),
    .y     (lvl2_p1)
  );

  // Stage 2: output register; y holds whenever no valid reaches it
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p2   <= '0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) y_p2 <= lvl2_p1;
    end
  end

  assign bus.y         = y_p2;
  assign bus.out_valid = vld_p2;

`else

  logic [W-1:0] y_p1;
  logic         vld_p1;

  mux_4x1 #(.W(W)) u_lvl2 (
    .lane0 (grp_p0[0]),
    .lane1 (grp_p0[1]),
    .lane2 (grp_p0[2]),
    .lane3 (grp_p0[3]),
    .sel   (bus.s[3:2]),
    .y     (lvl2_p1)
  );

  // Stage 1: output register; y holds whenever in_valid is low
  always_ff @(posedge clk) begin
    if (rst) begin
      y_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) y_p1 <= lvl2_p1;
    end
  end

  assign bus.y         = y_p1;
  assign bus.out_valid = vld_p1;

`endif

endmodule

// File: tb/tb_mux_16x1.sv
// Directed bench for mux_16x1 with W=1 and W=8 instances; adapts latency to MUX_16X1_PIPE2_EN.
module tb_mux_16x1;

`ifdef MUX_16X1_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_16x1_if #(.W(1)) bus1 ();
  mux_16x1_if #(.W(8)) bus8 ();

  mux_16x1 #(.W(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mux_16x1 #(.W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.d = '0; bus1.s = '0;
    bus8.in_valid = 1'b0; bus8.d = '0; bus8.s = '0;
    repeat (2) step();
    checks++; if (bus1.y !== 1'b0) begin errors++; $display("FAIL reset_y1 got %0h want 0", bus1.y); end
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov1 got %0b want 0", bus1.out_valid); end
    checks++; if (bus8.y !== 8'h00) begin errors++; $display("FAIL reset_y8 got %0h want 0", bus8.y); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset_ov8 got %0b want 0", bus8.out_valid); end
    rst = 1'b0;
  endtask

  task automatic test_w1_sweep();
    logic exp_tab [16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                           1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bus1.d = 16'b1111_1010_0001_0110;
    for (int c = 0; c < 15 + LAT; c++) begin
      bus1.in_valid = (c < 16);
      bus1.s        = 4'(c);
      step();
      if (c - LAT + 1 >= 0 && c - LAT + 1 < 16) begin
        checks++;
        if (bus1.y !== exp_tab[c-LAT+1]) begin
          errors++; $display("FAIL sweep_y s=%0d got %0b want %0b", c-LAT+1, bus1.y, exp_tab[c-LAT+1]);
        end
        checks++;
        if (bus1.out_valid !== 1'b1) begin
          errors++; $display("FAIL sweep_ov s=%0d got %0b want 1", c-LAT+1, bus1.out_valid);
        end
      end
    end
    bus1.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_release();
    bus1.d = 16'b1111_1010_0001_0110;
    bus1.in_valid = 1'b1;
    bus1.s = 4'd1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus1.y !== 1'b0) begin errors++; $display("FAIL rst_hold_y cyc=%0d got %0b want 0", i, bus1.y); end
      checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL rst_hold_ov cyc=%0d got %0b want 0", i, bus1.out_valid); end
    end
    rst = 1'b0;
    repeat (LAT) step();
    checks++; if (bus1.y !== 1'b1) begin errors++; $display("FAIL rst_release_y got %0b want 1", bus1.y); end
    checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL rst_release_ov got %0b want 1", bus1.out_valid); end
    bus1.in_valid = 1'b0;
    repeat (LAT + 1) step();
  endtask

  task automatic test_hold();
    bus1.d = 16'b1111_1010_0001_0110;
    bus1.s = 4'd9;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    bus1.s = 4'd0;
    bus1.d = '0;
    repeat (LAT - 1) step();
    checks++; if (bus1.y !== 1'b1) begin errors++; $display("FAIL hold_capture_y got %0b want 1", bus1.y); end
    checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL hold_capture_ov got %0b want 1", bus1.out_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus1.y !== 1'b1) begin errors++; $display("FAIL hold_y cyc=%0d got %0b want 1", i, bus1.y); end
      checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL hold_ov cyc=%0d got %0b want 0", i, bus1.out_valid); end
    end
  endtask

  task automatic test_w8_gaps();
    int         sched [$];
    logic [7:0] q [$];
    logic [7:0] exp_y;
    logic [7:0] last_y = 8'h00;
    int         accepted = 0;
    int         pulses = 0;
    for (int i = 0; i < 16; i++) bus8.d[i*8 +: 8] = 8'hA0 + 8'(i);
    for (int sv = 0; sv < 16; sv++) begin
      int gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) sched.push_back(-1);
      sched.push_back(sv);
    end
    for (int i = 0; i < LAT + 2; i++) sched.push_back(-1);
    foreach (sched[k]) begin
      if (sched[k] >= 0) begin
        bus8.in_valid = 1'b1;
        bus8.s = 4'(sched[k]);
        q.push_back(8'hA0 + 8'(sched[k]));
        accepted++;
      end else begin
        bus8.in_valid = 1'b0;
        bus8.s = 4'(k);
      end
      step();
      if (bus8.out_valid === 1'b1) begin
        pulses++;
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL gap_extra_pulse cyc=%0d got y=%0h want no pulse", k, bus8.y);
        end else begin
          exp_y = q.pop_front();
          checks++;
          if (bus8.y !== exp_y) begin errors++; $display("FAIL gap_y cyc=%0d got %0h want %0h", k, bus8.y, exp_y); end
          last_y = exp_y;
        end
      end else begin
        checks++;
        if (bus8.y !== last_y) begin errors++; $display("FAIL gap_hold_y cyc=%0d got %0h want %0h", k, bus8.y, last_y); end
      end
    end
    checks++;
    if (pulses != accepted) begin errors++; $display("FAIL gap_pulse_count got %0d want %0d", pulses, accepted); end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL gap_pending got %0d want 0", q.size()); end
  endtask

  task automatic test_midstream_reset();
    bus8.in_valid = 1'b1;
    bus8.s = 4'd3;
    rst = 1'b1;
    step();
    checks++; if (bus8.y !== 8'h00) begin errors++; $display("FAIL mid_rst_y got %0h want 0", bus8.y); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ov got %0b want 0", bus8.out_valid); end
    rst = 1'b0;
    bus8.in_valid = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_stale_ov cyc=%0d got %0b want 0", i, bus8.out_valid); end
      checks++; if (bus8.y !== 8'h00) begin errors++; $display("FAIL mid_rst_stale_y cyc=%0d got %0h want 0", i, bus8.y); end
    end
  endtask

  task automatic test_reset_between_stages();
    bus8.in_valid = 1'b1;
    bus8.s = 4'd5;
    step();
    bus8.in_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (bus8.y !== 8'h00) begin errors++; $display("FAIL between_rst_y got %0h want 0", bus8.y); end
    checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL between_rst_ov got %0b want 0", bus8.out_valid); end
    rst = 1'b0;
    for (int i = 0; i < LAT + 1; i++) begin
      step();
      checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL between_stale_ov cyc=%0d got %0b want 0", i, bus8.out_valid); end
      checks++; if (bus8.y !== 8'h00) begin errors++; $display("FAIL between_stale_y cyc=%0d got %0h want 0", i, bus8.y); end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_w1_sweep();
    test_reset_release();
    test_hold();
    test_w8_gaps();
    test_midstream_reset();
    test_reset_between_stages();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
